// File: rtl/matrix_pkg.sv
// Shared types and helpers for the N x N matrix multiplier family.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Result width: full signed product plus headroom for N-term sums.
  function automatic int ow_f(input int dw, input int n);
    return 2 * dw + clog2(n);
  endfunction

  function automatic int elem_off(input int row, input int col, input int n, input int w);
    return (row * n + col) * w;
  endfunction

endpackage

// File: rtl/matrix_mac.sv
// Signed DW x DW multiply with OW-wide accumulate; clear restarts the sum at zero.
module matrix_mac #(
  parameter int DW = 8,
  parameter int OW = 18
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [OW-1:0] acc,
  input  logic                 clear,
  output logic signed [OW-1:0] acc_next
);

  logic signed [2*DW-1:0] prod;

  assign prod     = a * b;
  assign acc_next = (clear ? '0 : acc) + OW'(prod);

endmodule

// File: rtl/matrix_mul_nxn.sv
// Sequential signed N x N matrix multiplier sharing one MAC over all N^3 products.
//   state | meaning
//   IDLE  | waiting for start; operands captured on accept
//   CALC  | one MAC per cycle, row-major i/j outer, k inner
//   DONE  | one-cycle completion pulse
module matrix_mul_nxn
  import matrix_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int OW = ow_f(DW, N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              acc_mode,
  input  logic [N*N*DW-1:0] a_flat,
  input  logic [N*N*DW-1:0] b_flat,
  output logic [N*N*OW-1:0] c_flat,
  output logic              busy,
  output logic              done
);

  localparam int IW = clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t state, state_nxt;

  logic [N*N*DW-1:0] a_reg, b_reg;
  logic [N*N*OW-1:0] c_reg;
  logic              acc_mode_r;
  logic [IW-1:0]     i, j, k;
  logic signed [OW-1:0] acc, acc_next, c_el;
  logic signed [DW-1:0] a_el, b_el;
  int                a_off, b_off, c_off;
  logic              last_mac;

  assign last_mac = (i == LAST) && (j == LAST) && (k == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_mac) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_comb begin
    a_off = elem_off(int'(i), int'(k), N, DW);
    b_off = elem_off(int'(k), int'(j), N, DW);
    c_off = elem_off(int'(i), int'(j), N, OW);
    a_el  = a_reg[a_off +: DW];
    b_el  = b_reg[b_off +: DW];
    c_el  = c_reg[c_off +: OW];
  end

  matrix_mac #(.DW(DW), .OW(OW)) u_mac (
    .a        (a_el),
    .b        (b_el),
    .acc      (acc),
    .clear    (k == '0),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      acc_mode_r <= 1'b0;
      acc        <= '0;
      i          <= '0;
      j          <= '0;
      k          <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg      <= a_flat;
          b_reg      <= b_flat;
          acc_mode_r <= acc_mode;
          acc        <= '0;
          i          <= '0;
          j          <= '0;
          k          <= '0;
        end
        CALC: begin
          acc <= acc_next;
          if (k == LAST) begin
            // accumulate mode wraps modulo 2^OW by design
            c_reg[c_off +: OW] <= acc_mode_r ? c_el + acc_next : acc_next;
            k <= '0;
            if (j == LAST) begin
              j <= '0;
              i <= (i == LAST) ? '0 : i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign c_flat = c_reg;

endmodule

// File: tb/tb_matrix_mul_nxn.sv
// Scoreboard bench for matrix_mul_nxn at N=2 and N=4 (DW=8).
module tb_matrix_mul_nxn;

  typedef logic [287:0] wide_t;
  typedef int vec_t [16];
  typedef struct {
    wide_t c;
    int    due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start2 = 1'b0, acc2 = 1'b0, busy2, done2;
  logic         start4 = 1'b0, acc4 = 1'b0, busy4, done4;
  logic [31:0]  a2 = '0, b2 = '0;
  logic [67:0]  c2;
  logic [127:0] a4 = '0, b4 = '0;
  logic [287:0] c4;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy_cnt2 = 0, busy_cnt4 = 0;
  int done_cnt2 = 0, done_cnt4 = 0;
  exp_t q2[$];
  exp_t q4[$];

  matrix_mul_nxn #(.N(2), .DW(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .acc_mode(acc2),
    .a_flat(a2), .b_flat(b2), .c_flat(c2), .busy(busy2), .done(done2)
  );

  matrix_mul_nxn #(.N(4), .DW(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .acc_mode(acc4),
    .a_flat(a4), .b_flat(b4), .c_flat(c4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input wide_t act, input wide_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic wide_t pack(input int n, input int w, input vec_t v);
    wide_t r;
    r = '0;
    for (int e = 0; e < n * n; e++)
      for (int b = 0; b < w; b++)
        r[e * w + b] = v[e][b];
    return r;
  endfunction

  // Monitors: pop expectation on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) busy_cnt2 = 0;
    else begin
      if (busy2) busy_cnt2++;
      if (done2) begin
        done_cnt2++;
        check("busy2_low_at_done", wide_t'(busy2), wide_t'(0));
        if (q2.size() == 0) check("unexpected_done2", wide_t'(1), wide_t'(0));
        else begin
          e = q2.pop_front();
          check("c2", {220'b0, c2}, e.c);
          check("done2_cycle", wide_t'(cyc), wide_t'(e.due));
          check("busy2_cycles", wide_t'(busy_cnt2), wide_t'(8));
        end
        busy_cnt2 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) busy_cnt4 = 0;
    else begin
      if (busy4) busy_cnt4++;
      if (done4) begin
        done_cnt4++;
        check("busy4_low_at_done", wide_t'(busy4), wide_t'(0));
        if (q4.size() == 0) check("unexpected_done4", wide_t'(1), wide_t'(0));
        else begin
          e = q4.pop_front();
          check("c4", c4, e.c);
          check("done4_cycle", wide_t'(cyc), wide_t'(e.due));
          check("busy4_cycles", wide_t'(busy_cnt4), wide_t'(64));
        end
        busy_cnt4 = 0;
      end
    end
  end

  task automatic drive_ops(input int sel, input vec_t va, input vec_t vb, input logic accm);
    wide_t ta, tb;
    ta = pack(sel, 8, va);
    tb = pack(sel, 8, vb);
    if (sel == 2) begin a2 = ta[31:0];  b2 = tb[31:0];  acc2 = accm; end
    else          begin a4 = ta[127:0]; b4 = tb[127:0]; acc4 = accm; end
  endtask

  task automatic issue(input int sel, input vec_t va, input vec_t vb, input logic accm,
                       input vec_t vc, input bit push);
    exp_t e;
    @(negedge clk);
    drive_ops(sel, va, vb, accm);
    if (sel == 2) start2 = 1'b1; else start4 = 1'b1;
    @(posedge clk);
    #1;
    e.c   = pack(sel, (sel == 2) ? 17 : 18, vc);
    e.due = cyc + sel * sel * sel;
    if (push) begin
      if (sel == 2) q2.push_back(e); else q4.push_back(e);
    end
    @(negedge clk);
    start2 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      seen = (sel == 2) ? done2 : done4;
    end
    if (!seen) check("done_timeout", wide_t'(0), wide_t'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb, vc, vi2, vones, vneg, vpos, v0, vi4, vr;
    int c0, d0;
    va  = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vb  = '{5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vi2 = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vr  = '{-128, 127, -1, 0, 5, -7, 100, -100, 33, -33, 64, -64, 1, 2, -2, 77};
    for (int e = 0; e < 16; e++) begin
      vones[e] = 1;
      vneg[e]  = -128;
      vpos[e]  = 127;
      vi4[e]   = (e % 5 == 0) ? 1 : 0;
      v0[e]    = 0;
    end

    repeat (3) @(negedge clk);
    check("rst_c2", {220'b0, c2}, '0);
    check("rst_busy2", wide_t'(busy2), '0);
    check("rst_done2", wide_t'(done2), '0);
    check("rst_c4", c4, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic product, then accumulate on top of it
    vc = '{19, 22, 43, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    issue(2, va, vb, 1'b0, vc, 1);
    wait_done(2);
    vc = '{38, 44, 86, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    issue(2, va, vb, 1'b1, vc, 1);
    wait_done(2);

    // signed extremes and identity at N=4
    for (int e = 0; e < 16; e++) vc[e] = 65536;
    issue(4, vneg, vneg, 1'b0, vc, 1);
    wait_done(4);
    for (int e = 0; e < 16; e++) vc[e] = -65024;
    issue(4, vneg, vpos, 1'b0, vc, 1);
    wait_done(4);
    issue(4, vi4, vr, 1'b0, vr, 1);
    wait_done(4);

    // start reasserted with other operands during CALC and in the done cycle
    vc = '{19, 22, 43, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    d0 = done_cnt2;
    issue(2, va, vb, 1'b0, vc, 1);
    repeat (2) @(negedge clk);
    drive_ops(2, vones, vones, 1'b1);
    start2 = 1'b1;
    wait_done(2);
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    repeat (20) @(negedge clk);
    check("reject_done_count", wide_t'(done_cnt2 - d0), wide_t'(1));
    check("reject_busy_idle", wide_t'(busy2), '0);

    // start held: second job accepted N^3+2 edges after the first
    d0 = done_cnt2;
    @(negedge clk);
    drive_ops(2, va, vb, 1'b0);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    q2.push_back('{c: pack(2, 17, vc), due: c0 + 8});
    q2.push_back('{c: pack(2, 17, vb), due: c0 + 18});
    @(negedge clk);
    drive_ops(2, vi2, vb, 1'b0);
    for (int t = 0; t < 40 && cyc < c0 + 10; t++) @(negedge clk);
    start2 = 1'b0;
    repeat (20) @(negedge clk);
    check("b2b_done_count", wide_t'(done_cnt2 - d0), wide_t'(2));

    // reset in the middle of a job
    d0 = done_cnt2;
    issue(2, vones, vb, 1'b0, v0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_c2", {220'b0, c2}, '0);
    check("midrst_busy2", wide_t'(busy2), '0);
    check("midrst_done2", wide_t'(done2), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", wide_t'(done_cnt2 - d0), '0);
    vc = '{19, 22, 43, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    issue(2, va, vb, 1'b0, vc, 1);
    wait_done(2);
    repeat (3) @(negedge clk);

    check("q2_drained", wide_t'(q2.size()), '0);
    check("q4_drained", wide_t'(q4.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
